// File: rtl/pomodoro_countdown_bcd.sv
// Pomodoro phase sequencer with a registered MM:SS BCD countdown for 7-segment decoders.
// Optional macro POMODORO_PRESCALER_EN derives the 1 Hz tick internally from CLK_HZ.
module pomodoro_countdown_bcd #(
    parameter int WORK_MIN        = 25,
    parameter int SHORT_BRK_MIN   = 5,
    parameter int LONG_BRK_MIN    = 15,
    parameter int CYCLES_PER_LONG = 4,
    parameter int CLK_HZ          = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       start_pause,
    input  logic       skip,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] phase,
    output logic       running,
    output logic       phase_done
);
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_WORK  = 2'd1,
        PH_SHORT = 2'd2,
        PH_LONG  = 2'd3
    } phase_e;

    localparam logic [3:0] WORK_T   = 4'(WORK_MIN / 10);
    localparam logic [3:0] WORK_O   = 4'(WORK_MIN % 10);
    localparam logic [3:0] SHORT_T  = 4'(SHORT_BRK_MIN / 10);
    localparam logic [3:0] SHORT_O  = 4'(SHORT_BRK_MIN % 10);
    localparam logic [3:0] LONG_T   = 4'(LONG_BRK_MIN / 10);
    localparam logic [3:0] LONG_O   = 4'(LONG_BRK_MIN % 10);
    localparam logic [3:0] LAST_CNT = 4'(CYCLES_PER_LONG - 1);

    phase_e     phase_q, phase_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
    logic       tick_src;
    logic       advance;
    logic       at_zero;

`ifdef POMODORO_PRESCALER_EN
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] ps_q, ps_d;
    logic          unused_tick_in;

    assign unused_tick_in = tick_1hz;
    assign tick_src       = (ps_q == PS_LAST);

    // Clearing on start_pause gives every resume a full first second.
    always_comb begin
        ps_d = ps_q + 1'b1;
        if (start_pause || tick_src) ps_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ps_q <= '0;
        else        ps_q <= ps_d;
    end
`else
    localparam int UNUSED_CLK_HZ = CLK_HZ;
    assign tick_src = tick_1hz;
`endif

    assign at_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);

    always_comb begin
        phase_d   = phase_q;
        running_d = running_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        mt_d      = mt_q;
        mo_d      = mo_q;
        st_d      = st_q;
        so_d      = so_q;
        advance   = 1'b0;

        if (skip && phase_q != PH_IDLE) begin
            advance = 1'b1;
        end else if (phase_q == PH_IDLE) begin
            if (start_pause) begin
                phase_d   = PH_WORK;
                running_d = 1'b1;
                mt_d      = WORK_T;
                mo_d      = WORK_O;
                st_d      = 4'd0;
                so_d      = 4'd0;
            end
        end else begin
            if (start_pause) running_d = ~running_q;
            // The tick is gated by the registered running flag, so a same-cycle toggle acts later.
            if (tick_src && running_q) begin
                if (at_zero) begin
                    advance = 1'b1;
                end else if (so_q != 4'd0) begin
                    so_d = so_q - 4'd1;
                end else begin
                    so_d = 4'd9;
                    if (st_q != 4'd0) begin
                        st_d = st_q - 4'd1;
                    end else begin
                        st_d = 4'd5;
                        if (mo_q != 4'd0) begin
                            mo_d = mo_q - 4'd1;
                        end else begin
                            mo_d = 4'd9;
                            mt_d = mt_q - 4'd1;
                        end
                    end
                end
            end
        end

        if (advance) begin
            done_d    = 1'b1;
            running_d = running_q;
            st_d      = 4'd0;
            so_d      = 4'd0;
            if (phase_q == PH_WORK) begin
                if (cnt_q == LAST_CNT) begin
                    phase_d = PH_LONG;
                    cnt_d   = 4'd0;
                    mt_d    = LONG_T;
                    mo_d    = LONG_O;
                end else begin
                    phase_d = PH_SHORT;
                    cnt_d   = cnt_q + 4'd1;
                    mt_d    = SHORT_T;
                    mo_d    = SHORT_O;
                end
            end else begin
                phase_d = PH_WORK;
                mt_d    = WORK_T;
                mo_d    = WORK_O;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= PH_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= 4'd0;
            mt_q      <= WORK_T;
            mo_q      <= WORK_O;
            st_q      <= 4'd0;
            so_q      <= 4'd0;
        end else begin
            phase_q   <= phase_d;
            running_q <= running_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            mt_q      <= mt_d;
            mo_q      <= mo_d;
            st_q      <= st_d;
            so_q      <= so_d;
        end
    end

    assign min_tens   = mt_q;
    assign min_ones   = mo_q;
    assign sec_tens   = st_q;
    assign sec_ones   = so_q;
    assign phase      = phase_q;
    assign running    = running_q;
    assign phase_done = done_q;
endmodule
